// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: initiator for one single-port RAM (cs/we/oe pins).
// Takes read/write requests on a valid/ready channel, drives the RAM pins
// from registers, and returns captured read data on a valid/ready response
// channel. Also counts completed writes and accepted read responses.
module ram_access_ctrl #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic          ram_oe,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [15:0]   wr_count,
  output logic [15:0]   rd_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   accept;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: WR and RD are single-cycle, RESP waits for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_write ? WR : RD;
      WR:      state_next = IDLE;
      RD:      state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM pin drivers: raised on acceptance, dropped on the edge that completes the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ram_addr  <= req_addr;
            ram_wdata <= req_wdata;
            ram_cs    <= 1'b1;
            ram_we    <= req_write;
            ram_oe    <= !req_write;
          end
        end
        WR: begin
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
        end
        RD: begin
          ram_cs <= 1'b0;
          ram_oe <= 1'b0;
        end
        default: begin
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          ram_oe <= 1'b0;
        end
      endcase
    end
  end

  // Response register: ram_rdata is only sampled leaving RD, when the RAM is actually driving it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (state == RD) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= ram_rdata;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Completion counters: a write counts on its completing edge, a read when its response is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count <= 16'd0;
      rd_count <= 16'd0;
    end else begin
      if (state == WR) begin
        wr_count <= wr_count + 16'd1;
      end
      if (state == RESP && rsp_ready) begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Testbench for ram_access_ctrl: a behavioural single-port RAM on the pin
// side plus an array/counter reference model of what the RAM should hold
// and what the counters should read.
module tb_ram_access_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          ram_cs;
  logic          ram_we;
  logic          ram_oe;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [15:0]   wr_count;
  logic [15:0]   rd_count;

  int n_compared = 0;
  int n_mismatched = 0;
  int cyc = 0;
  int proto_errs = 0;

  logic [DW-1:0] ref_mem [16];
  logic [15:0]   exp_wr = 16'd0;
  logic [15:0]   exp_rd = 16'd0;
  logic [DW-1:0] ram_mem [16];

  ram_access_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  // 100 MHz-style clock
  always #5 clk = ~clk;

  // Cycle counter used for acceptance spacing
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: writes on posedge when cs&we
  always @(posedge clk) begin
    if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_wdata;
  end

  // RAM model: drives data at negedge when cs&oe, otherwise floats
  always @(negedge clk) begin
    if (ram_cs && ram_oe) ram_rdata <= ram_mem[ram_addr];
    else ram_rdata <= 'z;
  end

  // Pin protocol monitor: we/oe exclusive and both low without cs
  always @(negedge clk) begin
    if ((ram_we && ram_oe) || (!ram_cs && (ram_we || ram_oe))) proto_errs <= proto_errs + 1;
  end

  // Safety net so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Present a request and return 1ns after the edge that accepts it
  task automatic issue_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    for (int k = 0; k < 50 && !req_ready; k++) begin
      @(posedge clk); #1;
    end
    n_compared++;
    if (req_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL accept_timeout: req_ready=%0b required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #3;
    n_compared++;
    if ({ram_cs, ram_we, ram_oe} !== 3'b000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_pins: got %b required 000", {ram_cs, ram_we, ram_oe});
    end
    n_compared++;
    if (ram_addr !== '0 || ram_wdata !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_addr_data: got %h/%h required 0/0", ram_addr, ram_wdata);
    end
    n_compared++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_rsp: got %b/%h required 0/0000", rsp_valid, rsp_rdata);
    end
    n_compared++;
    if (wr_count !== 16'd0 || rd_count !== 16'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_counts: got %0d/%0d required 0/0", wr_count, rd_count);
    end
    n_compared++;
    if (req_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_ready: got %b required 1", req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_wr = 16'd0;
    exp_rd = 16'd0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_compared++;
      if ({ram_cs, ram_we, ram_oe, rsp_valid} !== 4'b0000) begin
        n_mismatched++;
        $display("[TB] FAIL idle_quiet: cycle %0d got cs/we/oe/rv=%b required 0000", i, {ram_cs, ram_we, ram_oe, rsp_valid});
      end
    end
  endtask

  task automatic test_write_read();
    issue_req(1'b1, 4'd3, 16'hA5A5);
    ref_mem[3] = 16'hA5A5;
    n_compared++;
    if ({ram_cs, ram_we, ram_oe} !== 3'b110 || ram_addr !== 4'd3 || ram_wdata !== 16'hA5A5) begin
      n_mismatched++;
      $display("[TB] FAIL wr_pins: got cs/we/oe=%b addr=%h data=%h required 110/3/a5a5", {ram_cs, ram_we, ram_oe}, ram_addr, ram_wdata);
    end
    @(posedge clk); #1;
    exp_wr = exp_wr + 16'd1;
    n_compared++;
    if ({ram_cs, ram_we, ram_oe} !== 3'b000 || req_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL wr_done: got pins=%b ready=%b required 000/1", {ram_cs, ram_we, ram_oe}, req_ready);
    end
    n_compared++;
    if (wr_count !== exp_wr) begin
      n_mismatched++;
      $display("[TB] FAIL wr_count1: got %0d required %0d", wr_count, exp_wr);
    end
    rsp_ready = 1'b1;
    issue_req(1'b0, 4'd3, 16'h0000);
    n_compared++;
    if ({ram_cs, ram_we, ram_oe} !== 3'b101 || rsp_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL rd_pins: got pins=%b rv=%b required 101/0", {ram_cs, ram_we, ram_oe}, rsp_valid);
    end
    @(posedge clk); #1;
    n_compared++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[3]) begin
      n_mismatched++;
      $display("[TB] FAIL rd_resp: got rv=%b data=%h required 1/%h", rsp_valid, rsp_rdata, ref_mem[3]);
    end
    @(posedge clk); #1;
    exp_rd = exp_rd + 16'd1;
    rsp_ready = 1'b0;
    n_compared++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rd_count !== exp_rd) begin
      n_mismatched++;
      $display("[TB] FAIL rd_done: got rv=%b ready=%b rd_count=%0d required 0/1/%0d", rsp_valid, req_ready, rd_count, exp_rd);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue_req(1'b1, 4'd0, 16'h1234);
    @(posedge clk); #1;
    ref_mem[0] = 16'h1234;
    exp_wr = exp_wr + 16'd1;
    issue_req(1'b0, 4'd0, 16'h0000);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      n_compared++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[0] || req_ready !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL bp_hold: cycle %0d got rv=%b data=%h ready=%b required 1/%h/0", i, rsp_valid, rsp_rdata, req_ready, ref_mem[0]);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_rd = exp_rd + 16'd1;
    n_compared++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rd_count !== exp_rd) begin
      n_mismatched++;
      $display("[TB] FAIL bp_release: got rv=%b ready=%b rd_count=%0d required 0/1/%0d", rsp_valid, req_ready, rd_count, exp_rd);
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc [16];
    logic [DW-1:0] w;
    req_valid = 1'b1;
    req_write = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = DW'(i) * 16'h0101;
      req_addr  = AW'(i);
      req_wdata = w;
      for (int k = 0; k < 50 && !req_ready; k++) begin
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      acc_cyc[i] = cyc;
      ref_mem[i] = w;
      exp_wr = exp_wr + 16'd1;
      if (i > 0) begin
        n_compared++;
        if (acc_cyc[i] - acc_cyc[i-1] != 2) begin
          n_mismatched++;
          $display("[TB] FAIL b2b_spacing: accept %0d got spacing %0d required 2", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_compared++;
    if (wr_count !== exp_wr) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_wr_count: got %0d required %0d", wr_count, exp_wr);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      issue_req(1'b0, AW'(i), 16'h0000);
      @(posedge clk); #1;
      n_compared++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[i]) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_read: addr %0d got rv=%b data=%h required 1/%h", i, rsp_valid, rsp_rdata, ref_mem[i]);
      end
      @(posedge clk); #1;
      exp_rd = exp_rd + 16'd1;
    end
    rsp_ready = 1'b0;
    n_compared++;
    if (rd_count !== exp_rd) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_rd_count: got %0d required %0d", rd_count, exp_rd);
    end
  endtask

  task automatic test_random();
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            hold;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 15));
      d  = DW'($urandom);
      if (wr) begin
        issue_req(1'b1, a, d);
        n_compared++;
        if (ram_addr !== a || ram_wdata !== d || {ram_cs, ram_we, ram_oe} !== 3'b110) begin
          n_mismatched++;
          $display("[TB] FAIL rnd_wr_pins: op %0d got addr=%h data=%h required %h/%h", n, ram_addr, ram_wdata, a, d);
        end
        @(posedge clk); #1;
        ref_mem[a] = d;
        exp_wr = exp_wr + 16'd1;
        n_compared++;
        if (wr_count !== exp_wr) begin
          n_mismatched++;
          $display("[TB] FAIL rnd_wr_count: op %0d got %0d required %0d", n, wr_count, exp_wr);
        end
      end else begin
        rsp_ready = 1'b0;
        issue_req(1'b0, a, d);
        @(posedge clk); #1;
        hold = int'($urandom_range(0, 3));
        for (int h = 0; h <= hold; h++) begin
          n_compared++;
          if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[a]) begin
            n_mismatched++;
            $display("[TB] FAIL rnd_rd_data: op %0d addr %h got rv=%b data=%h required 1/%h", n, a, rsp_valid, rsp_rdata, ref_mem[a]);
          end
          if (h < hold) begin
            @(posedge clk); #1;
          end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_rd = exp_rd + 16'd1;
        n_compared++;
        if (rsp_valid !== 1'b0 || rd_count !== exp_rd) begin
          n_mismatched++;
          $display("[TB] FAIL rnd_rd_done: op %0d got rv=%b rd_count=%0d required 0/%0d", n, rsp_valid, rd_count, exp_rd);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    issue_req(1'b1, 4'd5, ~ref_mem[5]);
    #2 rst = 1'b1;
    #1;
    n_compared++;
    if (ram_cs !== 1'b0 || ram_we !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL rst_wr_pins: got cs=%b we=%b required 0/0", ram_cs, ram_we);
    end
    #2 rst = 1'b0;
    exp_wr = 16'd0;
    exp_rd = 16'd0;
    @(posedge clk); #1;
    n_compared++;
    if (wr_count !== exp_wr || ram_cs !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL rst_wr_count: got wr_count=%0d cs=%b required %0d/0", wr_count, ram_cs, exp_wr);
    end
    rsp_ready = 1'b1;
    issue_req(1'b0, 4'd5, 16'h0000);
    @(posedge clk); #1;
    n_compared++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[5]) begin
      n_mismatched++;
      $display("[TB] FAIL rst_wr_unchanged: got rv=%b data=%h required 1/%h", rsp_valid, rsp_rdata, ref_mem[5]);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_rd = exp_rd + 16'd1;
    n_compared++;
    if (rd_count !== exp_rd) begin
      n_mismatched++;
      $display("[TB] FAIL rst_wr_rd_count: got %0d required %0d", rd_count, exp_rd);
    end
  endtask

  task automatic test_reset_in_resp();
    rsp_ready = 1'b0;
    issue_req(1'b0, 4'd7, 16'h0000);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    n_compared++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL rst_resp_drop: got rv=%b ready=%b required 0/1", rsp_valid, req_ready);
    end
    #2 rst = 1'b0;
    exp_wr = 16'd0;
    exp_rd = 16'd0;
    @(posedge clk); #1;
    n_compared++;
    if (rsp_valid !== 1'b0 || rd_count !== exp_rd) begin
      n_mismatched++;
      $display("[TB] FAIL rst_resp_after: got rv=%b rd_count=%0d required 0/%0d", rsp_valid, rd_count, exp_rd);
    end
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    force dut.wr_count = 16'hFFFF;
    @(posedge clk); #1;
    release dut.wr_count;
    #1;
    exp_wr = 16'hFFFF;
    n_compared++;
    if (wr_count !== exp_wr) begin
      n_mismatched++;
      $display("[TB] FAIL wrap_preload: got %h required %h", wr_count, exp_wr);
    end
    issue_req(1'b1, 4'd9, 16'hBEEF);
    @(posedge clk); #1;
    ref_mem[9] = 16'hBEEF;
    exp_wr = exp_wr + 16'd1;
    n_compared++;
    if (wr_count !== exp_wr) begin
      n_mismatched++;
      $display("[TB] FAIL wrap_count: got %h required %h", wr_count, exp_wr);
    end
  endtask

  task automatic test_protocol();
    n_compared++;
    if (proto_errs != 0) begin
      n_mismatched++;
      $display("[TB] FAIL pin_protocol: got %0d violations required 0", proto_errs);
    end
  endtask

  // Test sequence
  initial begin
    $display("[TB] starting ram_access_ctrl bench");
    test_reset();
    test_idle();
    test_write_read();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    test_reset_in_resp();
    test_counter_wrap();
    test_idle();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
